gearbox_pair_arbiter: RTL
=========================

# gearbox_pair_arbiter

Shares one width-to-2*width packing stage between two upstream requesters, A and B. Arbitration is at pair granularity: once a requester's first beat is accepted, it keeps the grant until its second beat completes the pair or the pair times out. Pairs from different requesters are therefore never mixed. The block sits in front of the downstream 2*width consumer, takes the place of a bare 1:2 gearbox where two sources feed it, and tags each packed word with its source.

## Interface
- width, default 8: upstream beat width; downstream word is 2*width.
- timeout, default 8: consecutive stall cycles allowed mid-pair before the stored half is dropped; 0 disables the timeout.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst == 0 resets on the clock edge).
- a_vld  in  1  requester A beat valid.
- a_data  in  width  requester A beat.
- a_rdy  out  1  A beat accepted this cycle when a_vld & a_rdy.
- b_vld  in  1  requester B beat valid.
- b_data  in  width  requester B beat.
- b_rdy  out  1  B beat accepted this cycle when b_vld & b_rdy.
- down_vld  out  1  one-cycle pulse: packed word valid. No backpressure.
- down_data  out  2*width  packed word: {first beat, second beat}.
- down_src  out  1  source of down_data: 0 = A, 1 = B.
- drop  out  1  one-cycle pulse: a half pair was discarded on timeout.

## Operation
- States: IDLE (no stored beat) and HALF (first beat stored, grant held).
- Round-robin pointer `prio` selects the favoured requester; it resets to A.
- IDLE grant:
  - If only one requester is valid, it wins.
  - If both are valid, `prio` wins.
  - If neither is valid, there is no grant.
  - a_rdy/b_rdy equal the grant (combinational from vld and prio). Exactly one rdy is high when any vld is high; both are low otherwise.
  - An accepted beat is stored in the upper half. The granted source is latched and the state goes to HALF.
- HALF:
  - Only the latched source's rdy is high; the other requester's rdy is held low regardless of its vld.
  - An accepted beat completes the pair. Register down_data = {stored, new}, down_src = latched source, down_vld = 1. Go to IDLE and set prio to the other source.
- Timeout (timeout > 0):
  - A stall counter counts HALF cycles with no accept. It clears on any accept and on entry to HALF.
  - When the counter reaches timeout, discard the stored beat, go to IDLE, set prio to the other source, and pulse drop for one cycle.
  - Counter width is $clog2(timeout+1).
  - With timeout == 0, HALF waits indefinitely.
- Each pulse of down_vld or drop lasts one cycle. down_data and down_src hold their last value between pulses.
- Reset mid-pair discards the stored beat with no down_vld and no drop.

## Timing
- Reset values:
  - Outputs: down_vld 0, down_data 0, down_src 0, drop 0.
  - a_rdy follows a_vld, since the state resets to IDLE with prio = A.
  - Internal: state IDLE, stall counter 0.
- Latency: second beat accepted at edge N gives down_vld high in cycle N+1 (registered output).
- Throughput: one beat per cycle. Back-to-back pairs are supported, because the cycle after a pair completes is IDLE and can accept the next first beat while down_vld is high.
- Sustained full valid from both requesters gives alternating pairs A, B, A, B, with a_rdy high 2 cycles then b_rdy high 2 cycles.
- Timeout: entering HALF at edge T with no further accept gives drop high in cycle T+timeout+1 (the counter reaches timeout at edge T+timeout) and the rdy of an IDLE grant in the same cycle.
- If a beat is accepted on the cycle the counter would hit timeout, the accept wins: pair completes, no drop.
- down_vld and drop are never high in the same cycle.

## Test plan
- Reset with both vld high, width=8 -> down_vld=0, drop=0, down_data=0. After reset release, a_rdy=1 and b_rdy=0.
- A alone sends 0x12 then 0x34 on consecutive cycles -> one cycle later down_vld=1, down_data=0x1234, down_src=0. b_rdy stays 0 throughout.
- Both vld held high; A sends 0x01,0x02,0x03,0x04 and B sends 0x11,0x12 -> words 0x0102(A), 0x1112(B), 0x0304(A) on consecutive pairs with no idle cycle. A is never interleaved with B.
- A sends 0xAA, then a_vld low for 3 cycles while b_vld is high, then A sends 0xBB (timeout=8) -> b_rdy stays 0 during the stall; down_data=0xAABB, down_src=0. B is served next.
- A sends 0xAA, then a_vld low for 8 cycles (timeout=8) -> drop pulses once, no down_vld, and B (if valid) is granted in the same cycle as drop.
- rst asserted low in HALF after 0x55, then released; A sends 0x66, 0x77 -> down_data=0x6677. No word contains 0x55.

Source files
------------

// File: rtl/gearbox_pair_arbiter.sv
// Purpose: two-requester front end for a width -> 2*width packer; a grant is held per pair, output tagged by source.
// Latency: second beat accepted at edge N -> down_vld/down_data/down_src registered, visible in cycle N+1.
// Backpressure: upstream sees combinational rdy from grant state; downstream has none (down_vld is a pulse).
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   a_vld/a_data/a_rdy, b_vld/b_data/b_rdy   upstream requesters (beat accepted on vld & rdy)
//   down_vld        one-cycle pulse, packed word valid
//   down_data       {first beat, second beat}, holds between pulses
//   down_src        0 = A, 1 = B, holds between pulses
//   drop            one-cycle pulse when a stored half pair is discarded on stall timeout
module gearbox_pair_arbiter #(
  parameter int width   = 8,
  parameter int timeout = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_vld,
  input  logic [width-1:0]   a_data,
  output logic               a_rdy,
  input  logic               b_vld,
  input  logic [width-1:0]   b_data,
  output logic               b_rdy,
  output logic               down_vld,
  output logic [2*width-1:0] down_data,
  output logic               down_src,
  output logic               drop
);

  // A zero timeout still needs a legal (unused) counter width.
  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;
  // The stall counter would reach `timeout` on the edge where it currently
  // holds timeout-1; the drop is taken on that same edge.
  localparam logic [CW-1:0] STALL_LAST = (timeout > 0) ? CW'(timeout - 1) : '0;
  localparam logic [CW-1:0] STALL_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;       // favoured requester in IDLE: 0 = A, 1 = B
  logic             src;        // owner of the pair in progress
  logic [width-1:0] hold_dat;   // stored first beat
  logic [CW-1:0]    stall_cnt;

  logic             a_acc;
  logic             b_acc;
  logic             acc;
  logic [width-1:0] acc_dat;
  logic             tmo;

  assign a_acc   = a_vld & a_rdy;
  assign b_acc   = b_vld & b_rdy;
  assign acc     = a_acc | b_acc;
  assign acc_dat = a_acc ? a_data : b_data;

  // Accept on the last stall cycle beats the timeout because !acc gates it.
  assign tmo = (timeout > 0) && (state == HALF) && !acc && (stall_cnt == STALL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc) begin
          state_nxt = HALF;
        end
      end
      HALF: begin
        if (acc || tmo) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grant / ready. In HALF the owner's rdy is held high even
  // without vld so the other requester can never slip a beat into the pair.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    case (state)
      IDLE: begin
        a_rdy = a_vld & (~b_vld | ~prio);
        b_rdy = b_vld & (~a_vld |  prio);
      end
      HALF: begin
        a_rdy = ~src;
        b_rdy =  src;
      end
      default: begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
      end
    endcase
  end

  // Datapath, arbitration pointer, stall counter and output pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio      <= 1'b0;
      src       <= 1'b0;
      hold_dat  <= '0;
      stall_cnt <= '0;
      down_vld  <= 1'b0;
      down_data <= '0;
      down_src  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      down_vld <= 1'b0;
      drop     <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            hold_dat  <= acc_dat;
            src       <= b_acc;
            stall_cnt <= '0;
          end
        end
        HALF: begin
          if (acc) begin
            down_vld  <= 1'b1;
            down_data <= {hold_dat, acc_dat};
            down_src  <= src;
            prio      <= ~src;
            stall_cnt <= '0;
          end else if (tmo) begin
            drop      <= 1'b1;
            prio      <= ~src;
            stall_cnt <= '0;
          end else if (timeout > 0) begin
            stall_cnt <= stall_cnt + STALL_ONE;
          end
        end
        default: begin
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule
